// File: rtl/rr_grant_pkg.sv
// rr_grant_pkg
// Shared constants and the FSM state type for the round-robin grant
// controller. No ports; imported by rr_grant_ctrl and onehot_dec3to8.
package rr_grant_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_dec3to8.sv
// onehot_dec3to8
// Combinational 3-to-8 one-hot decoder. Exactly one output bit is set for
// every input value.
//   idx     in  3  binary index
//   onehot  out 8  one-hot decode of idx
module onehot_dec3to8
    import rr_grant_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl
// Round-robin controller sharing one 8-way one-hot resource between eight
// requesters. A grant is held until the owner pulses done, drops its
// request, or MAX_HOLD cycles elapse; every release is followed by one
// all-zero GAP cycle.
//
// Handshake: req[i] is a level held by requester i until it is served.
// A grant is issued by the FSM, not acknowledged; the owner ends it with a
// one-cycle done strobe (sampled only in GRANT) or by dropping req[i].
//
//   sys_clk    in  1  clock, rising edge
//   sys_rst_n  in  1  synchronous active-low reset
//   req        in  8  request levels
//   done       in  1  release strobe from the current owner
//   grant      out 8  one-hot grant, zero when not in GRANT
//   grant_idx  out 3  index of current/last owner
//   busy       out 1  high while in GRANT
//   timeout    out 1  one-cycle pulse after a hold-limit revocation
//   state      out 2  FSM state, exposed for debug/checkers
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               timeout,
    output state_t             state
);

    logic [IDX_W-1:0]   ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] dec_out;
    logic               limit_hit;
    logic               owner_req;

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    assign limit_hit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign owner_req = req[grant_idx];

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            hold_cnt  <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (win_found) begin
                        grant_idx <= win_idx;
                        hold_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= ST_GRANT;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (done || !owner_req || limit_hit) begin
                        state   <= ST_GAP;
                        busy    <= 1'b0;
                        ptr     <= grant_idx + 1'b1;
                        // done and request-drop take priority over the limit
                        timeout <= limit_hit && !done && owner_req;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    onehot_dec3to8 u_dec (
        .idx    (grant_idx),
        .onehot (dec_out)
    );

    // Decoded from registered index, gated by registered busy.
    assign grant = dec_out & {NUM_REQ{busy}};

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl
// Directed self-checking bench for rr_grant_ctrl. Inputs are driven and
// outputs are sampled 1 ns after each rising edge.
module tb_rr_grant_ctrl;
    import rr_grant_pkg::*;

    logic         sys_clk;
    logic         sys_rst_n;
    logic [7:0]   req;
    logic         done;
    logic [7:0]   grant;
    logic [2:0]   grant_idx;
    logic         busy;
    logic         timeout;
    state_t       state;

    int n_tests;
    int n_fail;

    rr_grant_ctrl #(.MAX_HOLD(16), .HOLD_W(5)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout),
        .state     (state)
    );

    // clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        done      = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [7:0] exp_g;
        n_tests   = 0;
        n_fail    = 0;
        sys_rst_n = 1'b0;
        req       = 8'hFF;
        done      = 1'b0;

        // Reset held 3 cycles with all requests
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_grant", grant, 8'h00);
            check("rst_busy", busy, 1'b0);
            check("rst_timeout", timeout, 1'b0);
        end
        sys_rst_n = 1'b1;
        tick();
        check("post_rst_grant", grant, 8'h01);
        check("post_rst_busy", busy, 1'b1);

        // Single owner, done on 4th grant cycle
        req = 8'h00;
        do_reset();
        req = 8'h08;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("single_grant", grant, 8'h08);
            done = (c == 4);
        end
        tick();
        done = 1'b0;
        check("single_gap", grant, 8'h00);
        check("single_gap_busy", busy, 1'b0);
        check("single_gap_to", timeout, 1'b0);
        tick();
        check("single_regrant", grant, 8'h08);
        check("single_idx", grant_idx, 3'd3);

        // Full rotation with wrap, done on 2nd grant cycle
        req = 8'h00;
        do_reset();
        req = 8'hFF;
        for (int j = 0; j <= 8; j++) begin
            exp_g = 8'h01 << (j % 8);
            tick();
            check("rot_c1", grant, exp_g);
            tick();
            check("rot_c2", grant, exp_g);
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rot_gap", grant, 8'h00);
        end

        // Hold limit without done
        req = 8'h00;
        do_reset();
        req = 8'h20;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("hold_grant", grant, 8'h20);
            check("hold_to_low", timeout, 1'b0);
        end
        tick();
        check("hold_gap", grant, 8'h00);
        check("hold_timeout", timeout, 1'b1);
        tick();
        check("hold_regrant", grant, 8'h20);
        check("hold_to_clear", timeout, 1'b0);
        // Hold limit reached together with done: no timeout
        for (int c = 2; c <= 16; c++) begin
            tick();
            check("hold2_grant", grant, 8'h20);
            done = (c == 16);
        end
        tick();
        done = 1'b0;
        check("hold2_gap", grant, 8'h00);
        check("hold2_timeout", timeout, 1'b0);
        tick();
        check("hold2_regrant", grant, 8'h20);

        // Owner drop
        req = 8'h81;
        do_reset();
        tick();
        check("drop_first", grant, 8'h01);
        req = 8'h80;
        tick();
        check("drop_gap", grant, 8'h00);
        check("drop_gap_to", timeout, 1'b0);
        tick();
        check("drop_next", grant, 8'h80);
        check("drop_idx", grant_idx, 3'd7);
        check("drop_to", timeout, 1'b0);

        // Reset mid-grant; ptr is nonzero when reset hits
        req = 8'h00;
        do_reset();
        req = 8'h30;
        tick();
        check("mid_first", grant, 8'h10);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("mid_gap", grant, 8'h00);
        tick();
        check("mid_second", grant, 8'h20);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        check("mid_rst_grant", grant, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_idx", grant_idx, 3'd0);
        tick();
        check("mid_after_rst", grant, 8'h10);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("mid_after_gap", grant, 8'h00);
        tick();
        check("mid_after_next", grant, 8'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
